pipe_add_sub: RTL and testbench
===============================

// Module: pipe_add_sub
// PURPOSE
//   Parametrised, pipelined two's-complement adder/subtractor for the ALU datapath.
//   Splits the WIDTH-bit carry chain into CHUNK-bit slices, one slice per stage.
//   Provides a valid/ready handshake on both sides, plus carry-out and status flags.
//   Generalises the combinational 4-bit adder to any width, adds subtraction and adds back-pressure.
// PARAMETERS
//   WIDTH   16  operand/result width in bits; must be a multiple of CHUNK.
//   CHUNK    4  bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (derived localparam).
// PORTS
//   clk        in   1      single clock; all state updates on the rising edge.
//   rst        in   1      asynchronous, active-high reset.
//   in_valid   in   1      a, b and sub are valid this cycle.
//   in_ready   out  1      block accepts the operation this cycle.
//   a          in   WIDTH  operand A.
//   b          in   WIDTH  operand B.
//   sub        in   1      0: A+B; 1: A-B.
//   out_valid  out  1      sum and flags are valid.
//   out_ready  in   1      downstream accepts the result.
//   sum        out  WIDTH  result, modulo 2^WIDTH.
//   cout       out  1      carry out of MSB (for subtraction: 1 = no borrow, i.e. A>=B unsigned).
//   ovf        out  1      signed overflow.
//   zero       out  1      sum == 0.
//   neg        out  1      sum[WIDTH-1].
// BEHAVIOUR
//   - Operation: B' = sub ? ~b : b; cin = sub; {cout,sum} = a + B' + cin.
//   - Signed overflow: ovf = (a[MSB] == B'[MSB]) && (sum[MSB] != a[MSB]).
//   - Stage k (0..STAGES-1) adds slice k, using the carry registered by stage k-1 (stage 0 uses cin).
//   - Unresolved upper operand slices travel in skew registers.
//   - Resolved lower sum slices travel in deskew registers.
//   - Global enable: adv = out_ready | ~out_valid. When adv=0, every pipeline register holds.
//   - in_ready = adv, combinational and with no dependence on in_valid.
//   - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//   - Latency: exactly STAGES cycles from the accepting edge to out_valid=1, when not stalled.
//   - Stall cycles add one-for-one. Throughput: 1 op/cycle.
//   - Bubbles are not collapsed. A valid bit travels with each slot; empty slots advance as bubbles.
//   - While out_valid=1 and out_ready=0:
//       - sum/cout/flags hold stable;
//       - in_ready=0;
//       - no operation is lost or duplicated.
//   - Results leave strictly in acceptance order.
//   - Reset (async, any cycle):
//       - all valid bits, data, carries and outputs go to 0 immediately;
//       - in_ready=1 while rst=1;
//       - in-flight operations are discarded;
//       - no stale result appears after release.
//   - STAGES=1 (CHUNK=WIDTH): a single registered adder with latency 1.
// CONFIGURATION
//   PIPE_ADD_SUB_FLAGS_EN defined:
//     - ovf, zero and neg are computed in the final stage;
//     - they are registered alongside sum.
//   PIPE_ADD_SUB_FLAGS_EN undefined:
//     - ovf, zero and neg are tied to 0; no flag logic is generated;
//     - sum, cout, handshake and latency are unchanged.
// TESTING  (WIDTH=16, CHUNK=4, latency 4; flags macro defined unless noted)
//   1. a=0x0000, b=0x0001, sub=0, out_ready=1
//      -> 4 cycles later: sum=0x0001, cout=0, ovf=0, zero=0, neg=0.
//   2. a=0xFFFF, b=0x0001, sub=0 (carry ripples through all 4 stages)
//      -> sum=0x0000, cout=1, zero=1, ovf=0.
//      Then a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, neg=1, cout=0.
//   3. sub=1: a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0, neg=1.
//      sub=1: a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
//   4. 8 back-to-back ops a=i, b=0x0100 (i=0..7); out_ready toggles 1,0,1,0...
//      -> 8 results 0x0100..0x0107 in order, none lost or repeated.
//      -> in_ready=0 exactly when out_valid=1 and out_ready=0; outputs stable during stall.
//   5. 3 ops in flight, assert rst mid-cycle for 2 cycles
//      -> out_valid=0 and sum=0 immediately.
//      -> After release, no output for 4 cycles without new input.
//      -> Next op 0x0002+0x0003 -> 0x0005.
//   6. WIDTH=4, CHUNK=4, macro undefined: a=4'b1111, b=4'b0011
//      -> 1 cycle later: sum=4'b0010, cout=1, ovf=0, zero=0, neg=0.

Source files
------------

// File: rtl/pipe_add_sub.sv
// Pipelined two's-complement add/sub: CHUNK bits of the carry chain resolved per stage, latency STAGES.
// One global enable stalls every stage when the output is held; optional flags under PIPE_ADD_SUB_FLAGS_EN.
module pipe_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic             adv;
    logic [WIDTH-1:0] b_eff;

    // Values presented to each stage: the module inputs for stage 0, the previous stage's flops otherwise.
    logic             src_vld [STAGES];
    logic             src_cy  [STAGES];
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];
    logic [WIDTH-1:0] src_s   [STAGES];
    logic [CHUNK:0]   slice   [STAGES];

    logic             vld_d [STAGES];
    logic             vld_q [STAGES];
    logic             cy_d  [STAGES];
    logic             cy_q  [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];

    always_comb begin
        adv   = out_ready | ~vld_q[LAST];
        b_eff = sub ? ~b : b;

        src_vld[0] = in_valid;
        src_cy[0]  = sub;
        src_a[0]   = a;
        src_b[0]   = b_eff;
        src_s[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = vld_q[k-1];
            src_cy[k]  = cy_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_s[k]   = s_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            slice[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                     + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, src_cy[k]};
            vld_d[k] = vld_q[k];
            cy_d[k]  = cy_q[k];
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            s_d[k]   = s_q[k];
            if (adv) begin
                vld_d[k] = src_vld[k];
                cy_d[k]  = slice[k][CHUNK];
                a_d[k]   = src_a[k];
                b_d[k]   = src_b[k];
                s_d[k]   = src_s[k];
                s_d[k][k*CHUNK +: CHUNK] = slice[k][CHUNK-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                cy_q[k]  <= cy_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = cy_q[LAST];

`ifdef PIPE_ADD_SUB_FLAGS_EN
    logic ovf_d, ovf_q, zero_d, zero_q, neg_d, neg_q;

    // Final-stage d values already hold when stalled, so the flags hold with them.
    always_comb begin
        ovf_d  = vld_d[LAST] & (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1])
                             & (s_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
        zero_d = vld_d[LAST] & (s_d[LAST] == '0);
        neg_d  = vld_d[LAST] & s_d[LAST][WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign neg  = neg_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
    assign neg  = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: a 16/4 instance checked against an arithmetic model every cycle,
// plus a 4/4 single-stage instance with directed checks.
module tb_pipe_add_sub;
`ifdef PIPE_ADD_SUB_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif
    localparam int STG = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, sub = 1'b0, out_valid, out_ready = 1'b1;
    logic [15:0] a = '0, b = '0, sum;
    logic        cout, ovf, zero, neg;

    logic        in_valid2 = 1'b0, in_ready2, sub2 = 1'b0, out_valid2, out_ready2 = 1'b1;
    logic [3:0]  a2 = '0, b2 = '0, sum2;
    logic        cout2, ovf2, zero2, neg2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg));

    pipe_add_sub #(.WIDTH(4), .CHUNK(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2), .neg(neg2));

    typedef struct {
        logic [15:0] sum;
        logic        cout, ovf, zero, neg;
        int          tag;
    } exp_t;

    exp_t        q[$];
    logic [15:0] got[$];
    int          adv_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_sum = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed/unsigned integer arithmetic rather than bit-level carry logic.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
        exp_t e;
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        int ux = int'(x);
        int uy = int'(y);
        int r  = s ? sx - sy : sx + sy;
        e.sum  = 16'(r);
        e.cout = s ? (ux >= uy) : (ux + uy > 65535);
        e.ovf  = FL & ((r > 32767) || (r < -32768));
        e.zero = FL & (e.sum == 16'h0000);
        e.neg  = FL & e.sum[15];
        e.tag  = 0;
        return e;
    endfunction

    // Compare process: adv_cnt counts enabled clock edges; a result is due STG-1 enabled edges after acceptance.
    always @(negedge clk) begin
        logic exp_v, m_adv;
        exp_t e;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 1);
        end else begin
            exp_v = (q.size() > 0) && (adv_cnt == q[0].tag + STG - 1);
            check("out_valid", out_valid, exp_v);
            check("in_ready", in_ready, !exp_v || out_ready);
            if (exp_v && out_valid) begin
                check("sum", sum, q[0].sum);
                check("cout", cout, q[0].cout);
                check("ovf", ovf, q[0].ovf);
                check("zero", zero, q[0].zero);
                check("neg", neg, q[0].neg);
            end
            if (prev_stall && out_valid) check("stall_hold", sum, prev_sum);
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            m_adv = !exp_v || out_ready;
            if (exp_v && out_ready) begin
                got.push_back(sum);
                void'(q.pop_front());
            end
            if (m_adv) begin
                adv_cnt++;
                if (in_valid) begin
                    e = model(a, b, sub);
                    e.tag = adv_cnt;
                    q.push_back(e);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic isub);
        int   n = 0;
        logic acc = 1'b0;
        a = ia; b = ib; sub = isub; in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("issue_timeout", 0, 1);
    endtask

    // Returns at the negedge where out_valid is first seen; lat counts negedges since issue returned.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
    endtask

    task automatic expect_res(input string name, input logic [15:0] es, input logic ec,
                              input logic eo, input logic ez, input logic en);
        int lat;
        wait_result(lat);
        check({name, "_lat"}, lat, STG);
        check({name, "_sum"}, sum, es);
        check({name, "_cout"}, cout, ec);
        check({name, "_ovf"}, ovf, FL & eo);
        check({name, "_zero"}, zero, FL & ez);
        check({name, "_neg"}, neg, FL & en);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int i;
        int cyc;
        int lat;
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_sum", sum, 16'h0000);
        check("reset_cout", cout, 0);
        check("reset_valid2", out_valid2, 0);
        check("reset_ready2", in_ready2, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single add, carry ripple, signed overflow
        issue(16'h0000, 16'h0001, 1'b0);
        expect_res("t1", 16'h0001, 0, 0, 0, 0);
        issue(16'hFFFF, 16'h0001, 1'b0);
        expect_res("t2a", 16'h0000, 1, 0, 1, 0);
        issue(16'h7FFF, 16'h0001, 1'b0);
        expect_res("t2b", 16'h8000, 0, 1, 0, 1);

        // Subtraction
        issue(16'h0003, 16'h0005, 1'b1);
        expect_res("t3a", 16'hFFFE, 0, 0, 0, 1);
        issue(16'h8000, 16'h0001, 1'b1);
        expect_res("t3b", 16'h7FFF, 1, 1, 0, 0);

        // Back-to-back with toggling out_ready
        got.delete();
        i = 0;
        cyc = 0;
        out_ready = 1'b0;
        while (got.size() < 8 && cyc < 200) begin
            out_ready = ~out_ready;
            if (i < 8) begin
                a = 16'(i); b = 16'h0100; sub = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) i++;
            cyc++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t4_count", got.size(), 8);
        for (int k = 0; k < got.size(); k++) check("t4_order", got[k], 16'h0100 + 16'(k));
        repeat (6) @(posedge clk);
        #1;

        // Reset with operations in flight and the output stalled
        issue(16'h0010, 16'h0001, 1'b0);
        issue(16'h0020, 16'h0002, 1'b0);
        issue(16'h0030, 16'h0003, 1'b0);
        out_ready = 1'b0;
        wait_result(lat);
        check("t5_pre_valid", out_valid, 1);
        check("t5_pre_sum", sum, 16'h0011);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_sum", sum, 16'h0000);
        check("t5_rst_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t5_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        issue(16'h0002, 16'h0003, 1'b0);
        expect_res("t5_next", 16'h0005, 0, 0, 0, 0);

        // Single-stage instance
        a2 = 4'b1111; b2 = 4'b0011; sub2 = 1'b0; in_valid2 = 1'b1;
        @(negedge clk);
        check("t6_in_ready", in_ready2, 1);
        check("t6_not_yet", out_valid2, 0);
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        @(negedge clk);
        check("t6_valid", out_valid2, 1);
        check("t6_sum", sum2, 4'b0010);
        check("t6_cout", cout2, 1);
        check("t6_ovf", ovf2, 0);
        check("t6_zero", zero2, 0);
        check("t6_neg", neg2, 0);
        @(negedge clk);
        check("t6_drained", out_valid2, 0);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
